// File: rtl/pgm_ddram_arbiter.sv
// pgm_ddram_arbiter: owns the shared DDRAM port in the 50 MHz domain.
// Serves CPU, video and audio reads with 4-phase req/ack handshakes and
// hands the port to the loader write path while a download is active.
//
// state | meaning
// IDLE  | pick next reader, or hand the port to the loader
// ISSUE | read granted, waiting for ddram_busy low to issue
// WAIT  | read outstanding, timeout counter running
// DONE  | owner acked, waiting for the owner to drop req
// LOAD  | loader owns the port, write signals passed through
module pgm_ddram_arbiter #(
  parameter int AW         = 29,
  parameter int STARVE_MAX = 4,
  parameter int TIMEOUT    = 1023
) (
  input  logic          clk,
  input  logic          reset_n,
  input  logic          cpu_req,
  input  logic [AW-1:0] cpu_addr,
  output logic          cpu_ack,
  output logic [63:0]   cpu_data,
  input  logic          vid_req,
  input  logic [AW-1:0] vid_addr,
  output logic          vid_ack,
  output logic [63:0]   vid_data,
  input  logic          aud_req,
  input  logic [AW-1:0] aud_addr,
  output logic          aud_ack,
  output logic [63:0]   aud_data,
  input  logic          dl_active,
  input  logic          dl_wr,
  input  logic [AW-1:0] dl_addr,
  input  logic [63:0]   dl_din,
  input  logic [7:0]    dl_be,
  output logic          ddram_rd,
  output logic          ddram_we,
  output logic [AW-1:0] ddram_addr,
  output logic [63:0]   ddram_din,
  output logic [7:0]    ddram_be,
  input  logic [63:0]   ddram_dout,
  input  logic          ddram_busy,
  input  logic          ddram_dout_ready,
  output logic          timeout_err
);

  localparam int TW = $clog2(TIMEOUT + 1);
  localparam int SW = $clog2(STARVE_MAX + 1);

  typedef enum logic [2:0] {S_IDLE, S_ISSUE, S_WAIT, S_DONE, S_LOAD} state_t;
  typedef enum logic [1:0] {OWN_CPU = 2'd0, OWN_VID = 2'd1, OWN_AUD = 2'd2} owner_t;

  state_t        state;
  owner_t        owner;
  owner_t        gnt_owner;
  logic [AW-1:0] rd_addr;
  logic [AW-1:0] gnt_addr;
  logic [TW-1:0] tmr;
  logic [SW-1:0] starve_cnt;
  logic          cpu_pend, vid_pend, aud_pend;
  logic          gnt_valid;
  logic          owner_req;
  logic          wait_end;
  logic [63:0]   ret_data;

  // A requester still holding ack has not yet completed its 4-phase cycle.
  assign cpu_pend = cpu_req & ~cpu_ack;
  assign vid_pend = vid_req & ~vid_ack;
  assign aud_pend = aud_req & ~aud_ack;

  // A read ends on returned data or on timeout; timeout returns all-ones.
  assign wait_end = ddram_dout_ready | (tmr == TW'(1));
  assign ret_data = ddram_dout_ready ? ddram_dout : '1;

  // Loader passthrough while in LOAD; read path keeps write controls idle.
  assign ddram_we   = (state == S_LOAD) & dl_wr;
  assign ddram_addr = (state == S_LOAD) ? dl_addr : rd_addr;
  assign ddram_din  = (state == S_LOAD) ? dl_din : '0;
  assign ddram_be   = (state == S_LOAD) ? dl_be : 8'hFF;

  // Grant selection: starving audio goes first, else CPU > video > audio.
  always_comb begin
    gnt_valid = 1'b1;
    gnt_owner = OWN_CPU;
    gnt_addr  = cpu_addr;
    if (aud_pend && starve_cnt == SW'(STARVE_MAX)) begin
      gnt_owner = OWN_AUD;
      gnt_addr  = aud_addr;
    end else if (cpu_pend) begin
      gnt_owner = OWN_CPU;
      gnt_addr  = cpu_addr;
    end else if (vid_pend) begin
      gnt_owner = OWN_VID;
      gnt_addr  = vid_addr;
    end else if (aud_pend) begin
      gnt_owner = OWN_AUD;
      gnt_addr  = aud_addr;
    end else begin
      gnt_valid = 1'b0;
    end
  end

  // Request level of the current owner, used to release its ack.
  always_comb begin
    case (owner)
      OWN_VID: owner_req = vid_req;
      OWN_AUD: owner_req = aud_req;
      default: owner_req = cpu_req;
    endcase
  end

  // Arbiter FSM with registered acks, read data, read strobe and error flag.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state       <= S_IDLE;
      owner       <= OWN_CPU;
      rd_addr     <= '0;
      tmr         <= '0;
      starve_cnt  <= '0;
      ddram_rd    <= 1'b0;
      cpu_ack     <= 1'b0;
      vid_ack     <= 1'b0;
      aud_ack     <= 1'b0;
      cpu_data    <= '0;
      vid_data    <= '0;
      aud_data    <= '0;
      timeout_err <= 1'b0;
    end else begin
      ddram_rd <= 1'b0;
      if (!aud_pend) starve_cnt <= '0;
      case (state)
        S_IDLE: begin
          if (dl_active) begin
            state <= S_LOAD;
          end else if (gnt_valid) begin
            owner   <= gnt_owner;
            rd_addr <= gnt_addr;
            state   <= S_ISSUE;
            if (aud_pend) begin
              if (gnt_owner == OWN_AUD) starve_cnt <= '0;
              else if (starve_cnt != SW'(STARVE_MAX)) starve_cnt <= starve_cnt + SW'(1);
            end
          end
        end
        S_ISSUE: begin
          if (!ddram_busy) begin
            ddram_rd <= 1'b1;
            tmr      <= TW'(TIMEOUT);
            state    <= S_WAIT;
          end
        end
        S_WAIT: begin
          if (wait_end) begin
            case (owner)
              OWN_VID: begin vid_data <= ret_data; vid_ack <= 1'b1; end
              OWN_AUD: begin aud_data <= ret_data; aud_ack <= 1'b1; end
              default: begin cpu_data <= ret_data; cpu_ack <= 1'b1; end
            endcase
            if (!ddram_dout_ready) timeout_err <= 1'b1;
            state <= S_DONE;
          end else begin
            tmr <= tmr - TW'(1);
          end
        end
        S_DONE: begin
          if (!owner_req) begin
            case (owner)
              OWN_VID: vid_ack <= 1'b0;
              OWN_AUD: aud_ack <= 1'b0;
              default: cpu_ack <= 1'b0;
            endcase
            state <= S_IDLE;
          end
        end
        S_LOAD: begin
          if (!dl_active) state <= S_IDLE;
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_pgm_ddram_arbiter.sv
// tb_pgm_ddram_arbiter: directed and randomized checks of the DDRAM arbiter
// against a memory model and a grant-order model derived from the
// arbitration rules (priority list plus audio starvation counter).
module tb_pgm_ddram_arbiter;
  localparam int AW = 29;
  localparam int SM = 4;
  localparam int TO = 1023;

  logic          clk = 1'b0;
  logic          reset_n;
  logic          cpu_req, vid_req, aud_req;
  logic [AW-1:0] cpu_addr, vid_addr, aud_addr;
  logic          cpu_ack, vid_ack, aud_ack;
  logic [63:0]   cpu_data, vid_data, aud_data;
  logic          dl_active, dl_wr;
  logic [AW-1:0] dl_addr;
  logic [63:0]   dl_din;
  logic [7:0]    dl_be;
  logic          ddram_rd, ddram_we;
  logic [AW-1:0] ddram_addr;
  logic [63:0]   ddram_din;
  logic [7:0]    ddram_be;
  logic [63:0]   ddram_dout;
  logic          ddram_busy, ddram_dout_ready;
  logic          timeout_err;

  pgm_ddram_arbiter #(.AW(AW), .STARVE_MAX(SM), .TIMEOUT(TO)) dut (
    .clk(clk), .reset_n(reset_n),
    .cpu_req(cpu_req), .cpu_addr(cpu_addr), .cpu_ack(cpu_ack), .cpu_data(cpu_data),
    .vid_req(vid_req), .vid_addr(vid_addr), .vid_ack(vid_ack), .vid_data(vid_data),
    .aud_req(aud_req), .aud_addr(aud_addr), .aud_ack(aud_ack), .aud_data(aud_data),
    .dl_active(dl_active), .dl_wr(dl_wr), .dl_addr(dl_addr), .dl_din(dl_din), .dl_be(dl_be),
    .ddram_rd(ddram_rd), .ddram_we(ddram_we), .ddram_addr(ddram_addr),
    .ddram_din(ddram_din), .ddram_be(ddram_be), .ddram_dout(ddram_dout),
    .ddram_busy(ddram_busy), .ddram_dout_ready(ddram_dout_ready),
    .timeout_err(timeout_err)
  );

  int total = 0;
  int bad = 0;
  int cyc = 0;

  logic [63:0]   mem [logic [AW-1:0]];
  int            resp_delay = 3;
  bit            resp_en = 1'b1;
  int            pend_cnt = 0;
  logic [AW-1:0] pend_addr;
  int            rd_cnt = 0;
  logic [AW-1:0] rd_addr_last = '0;
  int            rd_cyc = 0;
  int            resp_cyc = 0;
  logic [AW-1:0] raddr [3];
  bit   [2:0]    raised = 3'b000;
  int            order_q [$];

  initial forever #10 clk = ~clk;

  always @(posedge clk) cyc++;

  // DDRAM model: counts read strobes, answers each after resp_delay cycles
  initial begin
    ddram_dout_ready = 1'b0;
    ddram_dout = '0;
    forever begin
      @(negedge clk);
      ddram_dout_ready = 1'b0;
      ddram_dout = {$urandom, $urandom};
      if (pend_cnt > 0) begin
        pend_cnt--;
        if (pend_cnt == 0) begin
          ddram_dout = mem.exists(pend_addr) ? mem[pend_addr] : 64'h0;
          ddram_dout_ready = 1'b1;
          resp_cyc = cyc;
        end
      end
      if (ddram_rd === 1'b1) begin
        rd_cnt++;
        rd_addr_last = ddram_addr;
        rd_cyc = cyc;
        if (resp_en) begin
          pend_cnt = resp_delay;
          pend_addr = ddram_addr;
        end
      end
    end
  end

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic set_req(input int who, input logic v);
    case (who)
      0: cpu_req = v;
      1: vid_req = v;
      default: aud_req = v;
    endcase
  endtask

  task automatic set_addr(input int who, input logic [AW-1:0] a);
    case (who)
      0: cpu_addr = a;
      1: vid_addr = a;
      default: aud_addr = a;
    endcase
  endtask

  function automatic logic ack_of(input int who);
    return (who == 0) ? cpu_ack : (who == 1) ? vid_ack : aud_ack;
  endfunction

  function automatic logic [63:0] data_of(input int who);
    return (who == 0) ? cpu_data : (who == 1) ? vid_data : aud_data;
  endfunction

  task automatic new_addr(input int who);
    logic [AW-1:0] a;
    a = AW'($urandom);
    if (!mem.exists(a)) mem[a] = {$urandom, $urandom};
    raddr[who] = a;
    set_addr(who, a);
  endtask

  task automatic wait_ack(input int who, input int bound, output bit ok);
    ok = 1'b0;
    for (int i = 0; i < bound; i++) begin
      @(negedge clk);
      if (who < 0 ? (cpu_ack | vid_ack | aud_ack) : ack_of(who)) begin
        ok = 1'b1;
        break;
      end
    end
    chk("ack_wait", 64'(ok), 64'd1);
  endtask

  // Checks an acked read, drops req and confirms ack falls one cycle later
  task automatic finish_grant(input int who, input logic [63:0] exp, input bit lat);
    chk($sformatf("data_%0d", who), data_of(who), exp);
    if (lat) chk("ack_latency", 64'(cyc - resp_cyc), 64'd1);
    chk("rd_addr", 64'(rd_addr_last), 64'(raddr[who]));
    set_req(who, 1'b0);
    raised[who] = 1'b0;
    @(negedge clk);
    chk("ack_fall", 64'(ack_of(who)), 64'd0);
    chk("data_hold", data_of(who), exp);
  endtask

  task automatic serve_one(input int who, input logic [AW-1:0] a);
    bit ok;
    raddr[who] = a;
    set_addr(who, a);
    set_req(who, 1'b1);
    raised[who] = 1'b1;
    wait_ack(who, 200, ok);
    if (ok) finish_grant(who, mem[a], 1'b1);
    else begin
      set_req(who, 1'b0);
      raised[who] = 1'b0;
    end
  endtask

  // Raise start_mask together; requesters in rereq ask again right after
  // their ack drops while fewer than n_grants have been made. Every grant
  // is compared with the rule-level model: forced audio at STARVE_MAX,
  // otherwise first of CPU, video, audio.
  task automatic run_seq(input bit [2:0] start_mask, input bit [2:0] rereq, input int n_grants);
    int g, st, exp, got, rd0, nack;
    bit ok;
    g = 0;
    st = 0;
    rd0 = rd_cnt;
    order_q.delete();
    for (int i = 0; i < 3; i++)
      if (start_mask[i]) begin
        new_addr(i);
        set_req(i, 1'b1);
        raised[i] = 1'b1;
      end
    while (raised != 3'b000) begin
      if (raised[2] && st == SM) exp = 2;
      else if (raised[0]) exp = 0;
      else if (raised[1]) exp = 1;
      else exp = 2;
      if (!raised[2] || exp == 2) st = 0;
      else if (st < SM) st++;
      wait_ack(-1, 200, ok);
      if (!ok) begin
        cpu_req = 1'b0; vid_req = 1'b0; aud_req = 1'b0;
        raised = 3'b000;
        break;
      end
      nack = int'(cpu_ack) + int'(vid_ack) + int'(aud_ack);
      chk("ack_onehot", 64'(nack), 64'd1);
      got = cpu_ack ? 0 : vid_ack ? 1 : 2;
      chk("grant_order", 64'(got), 64'(exp));
      order_q.push_back(got);
      g++;
      finish_grant(got, mem[raddr[got]], 1'b1);
      if (rereq[got] && g < n_grants) begin
        new_addr(got);
        set_req(got, 1'b1);
        raised[got] = 1'b1;
      end
    end
    chk("seq_rd_count", 64'(rd_cnt - rd0), 64'(g));
  endtask

  initial begin
    bit ok;
    bit any_ack;
    int rd0, first_aud, we_pulses;
    logic [AW-1:0] wa;
    logic [63:0] wd;
    logic [7:0] wb;

    reset_n = 1'b0;
    cpu_req = 1'b0; vid_req = 1'b0; aud_req = 1'b0;
    cpu_addr = '0; vid_addr = '0; aud_addr = '0;
    dl_active = 1'b0; dl_wr = 1'b0; dl_addr = '0; dl_din = '0; dl_be = '0;
    ddram_busy = 1'b0;
    repeat (3) @(negedge clk);

    // reset values
    chk("rst_cpu_ack", 64'(cpu_ack), 64'd0);
    chk("rst_vid_ack", 64'(vid_ack), 64'd0);
    chk("rst_aud_ack", 64'(aud_ack), 64'd0);
    chk("rst_rd", 64'(ddram_rd), 64'd0);
    chk("rst_we", 64'(ddram_we), 64'd0);
    chk("rst_err", 64'(timeout_err), 64'd0);
    chk("rst_addr", 64'(ddram_addr), 64'd0);
    chk("rst_be", 64'(ddram_be), 64'hFF);
    chk("rst_cpu_data", cpu_data, 64'd0);
    chk("rst_vid_data", vid_data, 64'd0);
    chk("rst_aud_data", aud_data, 64'd0);
    reset_n = 1'b1;
    @(negedge clk);

    // single CPU read, data returned 5 cycles after the strobe
    mem[29'h100] = 64'h0123_4567_89AB_CDEF;
    resp_delay = 5;
    rd0 = rd_cnt;
    serve_one(0, 29'h100);
    chk("cpu_data_value", cpu_data, 64'h0123_4567_89AB_CDEF);
    chk("single_rd_count", 64'(rd_cnt - rd0), 64'd1);

    // three simultaneous requests
    resp_delay = 3;
    run_seq(3'b111, 3'b000, 3);
    chk("simul_count", 64'(order_q.size()), 64'd3);
    if (order_q.size() == 3) begin
      chk("simul_first", 64'(order_q[0]), 64'd0);
      chk("simul_second", 64'(order_q[1]), 64'd1);
      chk("simul_third", 64'(order_q[2]), 64'd2);
    end

    // audio held while CPU and video keep re-requesting
    run_seq(3'b111, 3'b011, 5);
    first_aud = -1;
    foreach (order_q[i]) if (order_q[i] == 2 && first_aud < 0) first_aud = i;
    chk("starve_first_audio", 64'(first_aud), 64'd4);

    // busy held for 20 cycles during ISSUE
    ddram_busy = 1'b1;
    rd0 = rd_cnt;
    new_addr(0);
    set_req(0, 1'b1);
    raised[0] = 1'b1;
    repeat (20) @(negedge clk);
    chk("busy_no_rd", 64'(rd_cnt - rd0), 64'd0);
    ddram_busy = 1'b0;
    wait_ack(0, 200, ok);
    if (ok) finish_grant(0, mem[raddr[0]], 1'b1);
    else begin set_req(0, 1'b0); raised[0] = 1'b0; end
    chk("busy_one_rd", 64'(rd_cnt - rd0), 64'd1);

    // read timeout on video
    chk("err_before_timeout", 64'(timeout_err), 64'd0);
    resp_en = 1'b0;
    new_addr(1);
    set_req(1, 1'b1);
    raised[1] = 1'b1;
    wait_ack(1, TO + 100, ok);
    if (ok) begin
      chk("timeout_window", 64'((cyc - rd_cyc >= TO - 1) && (cyc - rd_cyc <= TO + 1)), 64'd1);
      chk("timeout_err_set", 64'(timeout_err), 64'd1);
      finish_grant(1, 64'hFFFF_FFFF_FFFF_FFFF, 1'b0);
    end else begin
      set_req(1, 1'b0);
      raised[1] = 1'b0;
    end
    resp_en = 1'b1;
    new_addr(0);
    serve_one(0, raddr[0]);
    chk("err_sticky", 64'(timeout_err), 64'd1);

    // download starts while a read is outstanding
    resp_delay = 6;
    new_addr(0);
    set_req(0, 1'b1);
    raised[0] = 1'b1;
    ok = 1'b0;
    for (int i = 0; i < 50; i++) begin
      @(negedge clk);
      if (ddram_rd) begin ok = 1'b1; break; end
    end
    chk("dl_rd_seen", 64'(ok), 64'd1);
    repeat (2) @(negedge clk);
    dl_active = 1'b1;
    dl_wr = 1'b1;
    #1;
    chk("no_we_in_wait", 64'(ddram_we), 64'd0);
    dl_wr = 1'b0;
    wait_ack(0, 200, ok);
    if (ok) finish_grant(0, mem[raddr[0]], 1'b1);
    else begin set_req(0, 1'b0); raised[0] = 1'b0; end
    @(negedge clk);
    new_addr(1);
    set_req(1, 1'b1);
    raised[1] = 1'b1;
    rd0 = rd_cnt;
    we_pulses = 0;
    for (int k = 0; k < 3; k++) begin
      wa = AW'($urandom);
      wd = {$urandom, $urandom};
      wb = 8'($urandom);
      dl_addr = wa; dl_din = wd; dl_be = wb; dl_wr = 1'b1;
      #1;
      if (ddram_we) we_pulses++;
      chk("load_addr", 64'(ddram_addr), 64'(wa));
      chk("load_din", ddram_din, wd);
      chk("load_be", 64'(ddram_be), 64'(wb));
      @(negedge clk);
      dl_wr = 1'b0;
      #1;
      chk("load_we_low", 64'(ddram_we), 64'd0);
      @(negedge clk);
    end
    chk("load_we_pulses", 64'(we_pulses), 64'd3);
    chk("load_no_rd", 64'(rd_cnt - rd0), 64'd0);
    dl_active = 1'b0;
    wait_ack(1, 200, ok);
    if (ok) finish_grant(1, mem[raddr[1]], 1'b1);
    else begin set_req(1, 1'b0); raised[1] = 1'b0; end
    dl_wr = 1'b1;
    dl_be = 8'h00;
    #1;
    chk("idle_we_low", 64'(ddram_we), 64'd0);
    chk("idle_be_ff", 64'(ddram_be), 64'hFF);
    dl_wr = 1'b0;

    // randomized request mixes against the grant-order model
    for (int r = 0; r < 15; r++) begin
      resp_delay = $urandom_range(1, 6);
      run_seq(3'($urandom_range(1, 7)), 3'($urandom_range(0, 7)), $urandom_range(1, 6));
    end

    // reset pulse while a read is outstanding
    resp_delay = 5;
    new_addr(0);
    set_req(0, 1'b1);
    raised[0] = 1'b1;
    ok = 1'b0;
    for (int i = 0; i < 50; i++) begin
      @(negedge clk);
      if (ddram_rd) begin ok = 1'b1; break; end
    end
    chk("rst_rd_seen", 64'(ok), 64'd1);
    repeat (2) @(negedge clk);
    reset_n = 1'b0;
    #1;
    chk("midrst_cpu_ack", 64'(cpu_ack), 64'd0);
    chk("midrst_cpu_data", cpu_data, 64'd0);
    chk("midrst_rd", 64'(ddram_rd), 64'd0);
    chk("midrst_addr", 64'(ddram_addr), 64'd0);
    chk("midrst_be", 64'(ddram_be), 64'hFF);
    chk("midrst_err", 64'(timeout_err), 64'd0);
    set_req(0, 1'b0);
    raised[0] = 1'b0;
    @(negedge clk);
    reset_n = 1'b1;
    any_ack = 1'b0;
    repeat (12) begin
      @(negedge clk);
      any_ack |= cpu_ack | vid_ack | aud_ack;
    end
    chk("no_ack_after_reset", 64'(any_ack), 64'd0);
    new_addr(2);
    serve_one(2, raddr[2]);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
